// File: rtl/cpu_dbg_pkg.sv
// ---------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared types for the CPU run/step controller: the controller state
// encoding and the halt-cause codes reported to the debug host.
// ---------------------------------------------------------------------------
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_e;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_RESET = 2'd0;
  localparam cause_t CAUSE_HALT  = 2'd1;
  localparam cause_t CAUSE_STEP  = 2'd2;
  localparam cause_t CAUSE_BP    = 2'd3;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl_if
// Debug-side bundle of the run/step controller.
//   master : board/debug side, drives the requests and observes status
//   slave  : cpu_step_ctrl, consumes the requests and drives the status
// Signals:
//   run, step_req, step_count, halt_req, div    control requests
//   pc, bp_addr, bp_valid                       breakpoint compare inputs
//   cpu_en, busy, halted, halt_cause, steps_done status / advance strobe
// ---------------------------------------------------------------------------
interface cpu_step_ctrl_if
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) ();

  logic             run;
  logic             step_req;
  logic [CNT_W-1:0] step_count;
  logic             halt_req;
  logic [DIV_W-1:0] div;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_valid;
  logic             cpu_en;
  logic             busy;
  logic             halted;
  cause_t           halt_cause;
  logic [CNT_W-1:0] steps_done;

  modport master (
    output run, step_req, step_count, halt_req, div, pc, bp_addr, bp_valid,
    input  cpu_en, busy, halted, halt_cause, steps_done
  );

  modport slave (
    input  run, step_req, step_count, halt_req, div, pc, bp_addr, bp_valid,
    output cpu_en, busy, halted, halt_cause, steps_done
  );

endinterface

// File: rtl/cpu_step_ctrl_rate_tick.sv
// ---------------------------------------------------------------------------
// rate_tick
// Programmable rate divider. While enabled, tick is high for one cycle out
// of every div+1; the counter restarts from zero after each tick and is held
// at zero while clear is asserted.
// Ports:
//   click  in  clock, rising edge
//   rst_n  in  async active-low reset
//   clear  in  hold counter at zero
//   enable in  count / allow tick
//   div    in  tick spacing minus one
//   tick   out combinational tick, valid while enable is high
// ---------------------------------------------------------------------------
module rate_tick #(
  parameter int DIV_W = 16
) (
  input  logic             click,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;

  assign tick = enable && (count_q == div);

  // NOTE: sequential state is only ever written with non-blocking assignments
  // so every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge click or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl
// Run/step controller for the single-cycle CPU. Produces cpu_en, a one-cycle
// advance strobe that qualifies PC write, in free run, divided-rate run,
// N-instruction step and (optionally) PC-breakpoint modes.
// Ports:
//   click  in  system clock, rising edge
//   rst_n  in  async active-low reset
//   bus    cpu_step_ctrl_if.slave (requests in, status and cpu_en out)
// Configuration:
//   BREAKPOINT_EN  when defined, a tick with bp_valid && pc == bp_addr halts
//                  with cause 3 instead of issuing cpu_en. The first tick
//                  after leaving HALTED is exempt so a resume from the
//                  breakpoint PC executes that instruction once.
// ---------------------------------------------------------------------------
module cpu_step_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic           click,
  input  logic           rst_n,
  cpu_step_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic             cpu_en_q, cpu_en_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             busy;
  logic             tick;
  logic             bp_hit;

  assign busy = (state_q == RUN) || (state_q == STEP);

  // Held clear while halted, so it starts from zero on the edge we leave.
  rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
    .click  (click),
    .rst_n  (rst_n),
    .clear  (state_q == HALTED),
    .enable (busy),
    .div    (bus.div),
    .tick   (tick)
  );

`ifdef BREAKPOINT_EN
  logic skip_bp_q;

  // Set for as long as we sit in HALTED, i.e. on every exit; dropped after
  // the first tick of the new RUN/STEP session.
  always_ff @(posedge click or negedge rst_n) begin
    if (!rst_n) begin
      skip_bp_q <= 1'b0;
    end else if (state_q == HALTED) begin
      skip_bp_q <= 1'b1;
    end else if (tick) begin
      skip_bp_q <= 1'b0;
    end
  end

  assign bp_hit = bus.bp_valid && (bus.pc == bus.bp_addr) && !skip_bp_q;
`else
  logic [PC_W-1:0] unused_bp_addr;
  logic            unused_bp_valid;
  logic [PC_W-1:0] unused_pc;

  assign unused_bp_addr  = bus.bp_addr;
  assign unused_bp_valid = bus.bp_valid;
  assign unused_pc       = bus.pc;
  assign bp_hit          = 1'b0;
`endif

  // NOTE: every variable is given its hold/default value before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    cpu_en_d    = 1'b0;
    remaining_d = remaining_q;
    steps_d     = steps_q;

    unique case (state_q)
      HALTED: begin
        // step_req has priority over run; halt_req is meaningless here.
        if (bus.step_req) begin
          state_d     = STEP;
          remaining_d = (bus.step_count == '0) ? CNT_W'(1) : bus.step_count;
        end else if (bus.run) begin
          state_d = RUN;
        end
      end

      RUN, STEP: begin
        // Order matters: halt beats breakpoint beats a normal advance.
        if (bus.halt_req) begin
          state_d = HALTED;
          cause_d = CAUSE_HALT;
        end else if (tick) begin
          if (bp_hit) begin
            state_d = HALTED;
            cause_d = CAUSE_BP;
          end else begin
            cpu_en_d = 1'b1;
            steps_d  = steps_q + CNT_W'(1);
            if (state_q == STEP) begin
              remaining_d = remaining_q - CNT_W'(1);
              if (remaining_q == CNT_W'(1)) begin
                state_d = HALTED;
                cause_d = CAUSE_STEP;
              end
            end
          end
        end
      end

      default: begin
        state_d = HALTED;
      end
    endcase
  end

  always_ff @(posedge click or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HALTED;
      cause_q     <= CAUSE_RESET;
      cpu_en_q    <= 1'b0;
      remaining_q <= '0;
      steps_q     <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      cpu_en_q    <= cpu_en_d;
      remaining_q <= remaining_d;
      steps_q     <= steps_d;
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.busy       = busy;
  assign bus.halted     = (state_q == HALTED);
  assign bus.halt_cause = cause_q;
  assign bus.steps_done = steps_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_ctrl
// Self-checking bench for cpu_step_ctrl. Expected strobe positions are
// derived arithmetically: after entry at edge k, strobes fall on edges
// k + j*(div+1), j >= 1. The instruction count is a running modular total.
// A small PC model advances pc by 4 for each committed cpu_en.
// ---------------------------------------------------------------------------
module tb_cpu_step_ctrl;
  import cpu_dbg_pkg::*;

  localparam int PC_W  = 32;
  localparam int DIV_W = 16;
  localparam int CNT_W = 10;
  localparam int MOD   = 1 << CNT_W;

  logic click = 1'b0;
  logic rst_n;

  always #5 click = ~click;

  cpu_step_ctrl_if #(.PC_W(PC_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  cpu_step_ctrl #(.PC_W(PC_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .click (click),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int exp_steps = 0;
  bit en_prev   = 1'b0;
  bit pc_follow = 1'b0;

  // One clock: wait for the edge, sample 1 ns later, let the CPU model
  // commit the instruction strobed during the previous cycle.
  task automatic cycle();
    @(posedge click);
    #1;
    if (pc_follow && en_prev) bus.pc = bus.pc + 32'd4;
    en_prev = bus.cpu_en;
  endtask

  task automatic check_steps(input string name);
    logic [CNT_W-1:0] exp_sd;
    exp_sd = CNT_W'(exp_steps);
    checks++;
    if (bus.steps_done !== exp_sd) begin
      failures++;
      $display("FAIL %s steps_done: got %0d expected %0d", name, bus.steps_done, exp_sd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_en !== 1'b0 ||
        bus.halt_cause !== CAUSE_RESET || bus.steps_done !== '0) begin
      failures++;
      $display("FAIL reset_init: got halted=%b busy=%b en=%b cause=%0d steps=%0d expected 1 0 0 0 0",
               bus.halted, bus.busy, bus.cpu_en, bus.halt_cause, bus.steps_done);
    end
    #9 rst_n = 1'b1;
    cycle();
    cycle();
    checks++;
    if (bus.halted !== 1'b1 || bus.cpu_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got halted=%b en=%b expected 1 0", bus.halted, bus.cpu_en);
    end
    // Enter free run at div 0, let a few strobes happen, then reset mid-cycle.
    bus.div = '0;
    bus.run = 1'b1;
    cycle();
    bus.run = 1'b0;
    cycle();
    cycle();
    checks++;
    if (bus.cpu_en !== 1'b1 || bus.steps_done === '0) begin
      failures++;
      $display("FAIL reset_prerun: got en=%b steps=%0d expected en=1 steps>0", bus.cpu_en, bus.steps_done);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cpu_en !== 1'b0 || bus.halted !== 1'b1 || bus.busy !== 1'b0 ||
        bus.halt_cause !== CAUSE_RESET || bus.steps_done !== '0) begin
      failures++;
      $display("FAIL reset_async: got en=%b halted=%b busy=%b cause=%0d steps=%0d expected 0 1 0 0 0",
               bus.cpu_en, bus.halted, bus.busy, bus.halt_cause, bus.steps_done);
    end
    exp_steps = 0;
    #2 rst_n = 1'b1;
    cycle();
    cycle();
    checks++;
    if (bus.cpu_en !== 1'b0 || bus.halted !== 1'b1) begin
      failures++;
      $display("FAIL reset_after: got en=%b halted=%b expected 0 1", bus.cpu_en, bus.halted);
    end
    en_prev = 1'b0;
  endtask

  // Free run at rate d for len cycles after entry, then a halt_req pulse.
  task automatic test_run(input int d, input int len);
    int bad;
    int got;
    bit exp_en;
    bus.div = DIV_W'(d);
    bus.run = 1'b1;
    cycle();
    bus.run = 1'b0;  // dropping run must not stop the session
    checks++;
    if (bus.busy !== 1'b1 || bus.cpu_en !== 1'b0) begin
      failures++;
      $display("FAIL run_entry d=%0d: got busy=%b en=%b expected 1 0", d, bus.busy, bus.cpu_en);
    end
    bad = 0;
    got = 0;
    for (int m = 1; m <= len; m++) begin
      cycle();
      exp_en = (m % (d + 1)) == 0;
      if (bus.cpu_en !== exp_en || bus.busy !== 1'b1) bad++;
      if (exp_en) got++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL run_pattern d=%0d len=%0d: got %0d wrong cycles expected 0", d, len, bad);
    end
    exp_steps = (exp_steps + got) % MOD;
    bus.halt_req = 1'b1;
    cycle();
    bus.halt_req = 1'b0;
    checks++;
    if (bus.cpu_en !== 1'b0 || bus.halted !== 1'b1 || bus.halt_cause !== CAUSE_HALT) begin
      failures++;
      $display("FAIL run_halt d=%0d len=%0d: got en=%b halted=%b cause=%0d expected 0 1 1",
               d, len, bus.cpu_en, bus.halted, bus.halt_cause);
    end
    check_steps("run");
    // halt_req while already halted changes nothing
    bus.halt_req = 1'b1;
    cycle();
    bus.halt_req = 1'b0;
    cycle();
    checks++;
    if (bus.halted !== 1'b1 || bus.cpu_en !== 1'b0 || bus.halt_cause !== CAUSE_HALT) begin
      failures++;
      $display("FAIL halted_ignore: got halted=%b en=%b cause=%0d expected 1 0 1",
               bus.halted, bus.cpu_en, bus.halt_cause);
    end
  endtask

  // N-step at rate d; with_run also raises run in the same cycle.
  task automatic test_step(input int n, input int d, input bit with_run);
    int nn;
    int budget;
    int last;
    bit done;
    int q[$];
    int bad;
    nn = (n == 0) ? 1 : n;
    budget = nn * (d + 1) + 4;
    bus.div = DIV_W'(d);
    bus.step_count = CNT_W'(n);
    bus.step_req = 1'b1;
    bus.run = with_run;
    cycle();
    bus.step_req = 1'b0;
    bus.run = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.cpu_en !== 1'b0) begin
      failures++;
      $display("FAIL step_entry n=%0d d=%0d: got busy=%b en=%b expected 1 0", n, d, bus.busy, bus.cpu_en);
    end
    done = 1'b0;
    last = 0;
    for (int m = 1; m <= budget && !done; m++) begin
      cycle();
      if (bus.cpu_en === 1'b1) q.push_back(m);
      if (bus.halted === 1'b1) begin
        done = 1'b1;
        last = m;
      end
    end
    checks++;
    if (!done || last != nn * (d + 1)) begin
      failures++;
      $display("FAIL step_done_time n=%0d d=%0d: got done=%b at %0d expected at %0d", n, d, done, last, nn * (d + 1));
    end
    bad = 0;
    foreach (q[j]) if (q[j] != (j + 1) * (d + 1)) bad++;
    checks++;
    if (q.size() != nn || bad != 0) begin
      failures++;
      $display("FAIL step_strobes n=%0d d=%0d: got %0d strobes (%0d misplaced) expected %0d", n, d, q.size(), bad, nn);
    end
    checks++;
    if (bus.halt_cause !== CAUSE_STEP) begin
      failures++;
      $display("FAIL step_cause: got %0d expected %0d", bus.halt_cause, CAUSE_STEP);
    end
    exp_steps = (exp_steps + nn) % MOD;
    check_steps("step");
    if (with_run) begin
      cycle();
      cycle();
      checks++;
      if (bus.halted !== 1'b1 || bus.cpu_en !== 1'b0) begin
        failures++;
        $display("FAIL step_beats_run: got halted=%b en=%b expected 1 0", bus.halted, bus.cpu_en);
      end
    end
  endtask

  task automatic test_breakpoint();
    int d;
    int strobes;
    int hm;
    bit stopped;
    d = $urandom_range(1, 4);
    pc_follow   = 1'b1;
    en_prev     = 1'b0;
    bus.pc      = '0;
    bus.bp_addr = 32'h10;
    bus.bp_valid = 1'b1;
    bus.div = DIV_W'(d);
    bus.run = 1'b1;
    cycle();
    bus.run = 1'b0;
    strobes = 0;
    stopped = 1'b0;
    hm = 0;
    for (int m = 1; m <= 6 * (d + 1) && !stopped; m++) begin
      cycle();
      if (bus.cpu_en === 1'b1) strobes++;
      if (bus.halted === 1'b1) begin
        stopped = 1'b1;
        hm = m;
      end
    end
`ifdef BREAKPOINT_EN
    checks++;
    if (!stopped || hm != 5 * (d + 1) || strobes != 4 || bus.halt_cause !== CAUSE_BP || bus.pc !== 32'h10) begin
      failures++;
      $display("FAIL bp_hit d=%0d: got stop=%b at %0d strobes=%0d cause=%0d pc=%h expected 1 at %0d 4 3 10",
               d, stopped, hm, strobes, bus.halt_cause, bus.pc, 5 * (d + 1));
    end
    exp_steps = (exp_steps + 4) % MOD;
    check_steps("bp");
    // Resume from the breakpoint PC: the first strobe executes it.
    bus.run = 1'b1;
    cycle();
    bus.run = 1'b0;
    for (int m = 1; m <= d + 1; m++) cycle();
    checks++;
    if (bus.cpu_en !== 1'b1 || bus.pc !== 32'h10 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume: got en=%b pc=%h busy=%b expected 1 10 1", bus.cpu_en, bus.pc, bus.busy);
    end
    bus.halt_req = 1'b1;
    cycle();
    bus.halt_req = 1'b0;
    exp_steps = (exp_steps + 1) % MOD;
    checks++;
    if (bus.halt_cause !== CAUSE_HALT || bus.pc !== 32'h14) begin
      failures++;
      $display("FAIL bp_resume_halt: got cause=%0d pc=%h expected 1 14", bus.halt_cause, bus.pc);
    end
    // 2-step from 0xC: first strobe moves pc to the breakpoint, second tick
    // hits it, so the break wins over step completion.
    bus.pc = 32'hC;
    en_prev = 1'b0;
    bus.step_count = CNT_W'(2);
    bus.step_req = 1'b1;
    cycle();
    bus.step_req = 1'b0;
    strobes = 0;
    stopped = 1'b0;
    for (int m = 1; m <= 3 * (d + 1) && !stopped; m++) begin
      cycle();
      if (bus.cpu_en === 1'b1) strobes++;
      if (bus.halted === 1'b1) stopped = 1'b1;
    end
    checks++;
    if (!stopped || strobes != 1 || bus.halt_cause !== CAUSE_BP) begin
      failures++;
      $display("FAIL bp_beats_step: got stop=%b strobes=%0d cause=%0d expected 1 1 3", stopped, strobes, bus.halt_cause);
    end
    exp_steps = (exp_steps + 1) % MOD;
    check_steps("bp_step");
`else
    checks++;
    if (stopped || strobes != 6 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_disabled d=%0d: got stop=%b strobes=%0d busy=%b expected 0 6 1", d, stopped, strobes, bus.busy);
    end
    bus.halt_req = 1'b1;
    cycle();
    bus.halt_req = 1'b0;
    exp_steps = (exp_steps + 6) % MOD;
    checks++;
    if (bus.halt_cause !== CAUSE_HALT || bus.halted !== 1'b1) begin
      failures++;
      $display("FAIL bp_disabled_halt: got cause=%0d halted=%b expected 1 1", bus.halt_cause, bus.halted);
    end
    check_steps("bp_off");
`endif
    bus.bp_valid = 1'b0;
    pc_follow = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    n = (MOD - 1) - exp_steps;
    if (n > 0) test_step(n, 0, 1'b0);
    checks++;
    if (bus.steps_done !== CNT_W'(MOD - 1)) begin
      failures++;
      $display("FAIL wrap_top: got %0d expected %0d", bus.steps_done, MOD - 1);
    end
    test_step(1, 0, 1'b0);
    checks++;
    if (bus.steps_done !== '0) begin
      failures++;
      $display("FAIL wrap_zero: got %0d expected 0", bus.steps_done);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bus.run        = 1'b0;
    bus.step_req   = 1'b0;
    bus.step_count = '0;
    bus.halt_req   = 1'b0;
    bus.div        = '0;
    bus.pc         = '0;
    bus.bp_addr    = '0;
    bus.bp_valid   = 1'b0;

    test_reset();
    test_run(0, 3);            // strobes 1,2,3 after entry; halt on a tick edge
    test_step(2, 3, 1'b0);     // two strobes 4 cycles apart
    test_step(0, 3, 1'b0);     // count 0 behaves as 1
    test_step(3, 1, 1'b1);     // step_req beats run
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(0, 4);
      test_run(d, $urandom_range(1, 4) * (d + 1) - 1);  // halt lands on tick
      test_run($urandom_range(0, 4), $urandom_range(1, 12));
      test_step($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    test_breakpoint();
    test_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
